fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 Parameter ADDR_BASE, default 32'h00003000: lowest legal fetch address.
REQ-003 Parameter ADDR_LIMIT, default 32'h00006FFF: highest legal fetch address.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  fetch stage presents a PC/instruction pair.
REQ-007 in_ready  output  1  queue can accept a pair this cycle.
REQ-008 in_pc  input  32  PC of the fetched instruction.
REQ-009 in_instr  input  32  instruction word read at in_pc.
REQ-010 flush  input  1  discard all queued entries (branch/exception redirect).
REQ-011 out_valid  output  1  head entry is available to decode.
REQ-012 out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 out_pc  output  32  PC of head entry.
REQ-014 out_instr  output  32  instruction of head entry.
REQ-015 out_exc  output  5  exception code of head entry: 0 none, 4 AdEL.
REQ-016 out_count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Push occurs on posedge when in_valid=1, in_ready=1, flush=0; entry stores in_pc, checked instruction, exception code.
REQ-018 in_ready SHALL equal (count < DEPTH), combinational from registered count only; no dependence on out_ready (no full-pass-through).
REQ-019 Pop occurs on posedge when out_valid=1, out_ready=1, flush=0; head pointer advances by one.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-022 out_valid SHALL equal (count != 0); no bypass: a pushed entry is visible at out_* one cycle after its push edge (latency 1).
REQ-023 When out_valid=0: out_pc=0, out_instr=0, out_exc=0.
REQ-024 Address check at push: if in_pc[1:0] != 0, or in_pc < ADDR_BASE, or in_pc > ADDR_LIMIT (unsigned), store exc=4 and instruction 32'h00000000; otherwise exc=0 and in_instr.
REQ-025 flush=1 on a posedge: count, read pointer, write pointer all become 0; any simultaneous push and pop are ignored.
REQ-026 Push while full and pop while empty are impossible by REQ-018/REQ-022; state SHALL remain unchanged if in_valid=1 while full.
REQ-027 Entry storage contents need no reset; only pointers and count are reset.

Reset
REQ-028 reset=0 SHALL immediately (without clk edge) force count=0, pointers=0, hence out_valid=0, in_ready=1, out_pc/out_instr/out_exc=0, out_count=0.
REQ-029 Reset asserted mid-operation SHALL drop all queued entries; first push after reset=1 lands in entry 0.
REQ-030 No push or pop SHALL occur on a posedge while reset=0.

Verification
REQ-031 Reset, then push PCs 0x3000,0x3004,0x3008,0x300C (instr 0xA..0xD), out_ready=0 -> out_count=4, in_ready=0, out_pc=0x3000, out_instr=0xA.
REQ-032 From full, out_ready=1 and in_valid=1 for 6 cycles -> pops 0x3000..0x300C in order, in_ready returns 1 after first pop, pointers wrap with no loss or duplication.
REQ-033 Push 0x3002, then 0x2FFC, then 0x7000 -> each head shows out_exc=4, out_instr=0; push 0x6FFC -> out_exc=0.
REQ-034 Queue holding 3 entries, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle out_count=0, out_valid=0, pushed entry absent.
REQ-035 Count=2, simultaneous push and pop for 10 cycles -> out_count stays 2, output order equals input order.
REQ-036 Assert reset=0 between clock edges with count=3 -> out_valid=0 and out_count=0 before next posedge; after release, push 0x3000 appears at out_pc one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: a small in-order FIFO between instruction fetch and decode.
// Each entry holds a PC, the instruction word and an exception code. The
// fetch address is range- and alignment-checked on the way in, so decode
// sees an AdEL-tagged, zeroed instruction for any illegal fetch address.
//
// Handshake: both sides use strict valid/ready. A transfer happens on a
// rising clk edge when valid and ready are both 1 on that side and flush is
// 0. in_ready depends only on the registered count (never on out_ready), and
// out_valid depends only on the registered count (no bypass), so a pushed
// entry is visible at out_* exactly one cycle after its push edge. Once
// valid is raised, the producer holds its payload stable until accepted.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_3000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_6FFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [4:0]                 out_exc,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Entry storage: no reset, only the pointers and count define validity.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [4:0]  exc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  logic addr_bad;
  logic [31:0] chk_instr;
  logic [4:0]  chk_exc;

  // Occupancy-derived handshake flags, purely from registered state.
  always_comb begin
    in_ready  = (count < CNT_W'(DEPTH));
    out_valid = (count != '0);
    out_count = count;
  end

  // Transfer qualifiers; flush overrides both directions.
  always_comb begin
    push = in_valid & in_ready & ~flush;
    pop  = out_valid & out_ready & ~flush;
  end

  // Fetch address check: misaligned or outside [ADDR_BASE, ADDR_LIMIT].
  always_comb begin
    addr_bad = (in_pc[1:0] != 2'b00) || (in_pc < ADDR_BASE) || (in_pc > ADDR_LIMIT);
    if (addr_bad) begin
      chk_instr = 32'h0000_0000;
      chk_exc   = EXC_ADEL;
    end else begin
      chk_instr = in_instr;
      chk_exc   = EXC_NONE;
    end
  end

  // Write the checked entry at the tail; held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= chk_instr;
      exc_mem[wr_ptr]   <= chk_exc;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide, so +1 wraps DEPTH-1 -> 0.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry presented to decode, forced to zero when the queue is empty.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_exc   = '0;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
      out_exc   = exc_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a scoreboard.
// Accepted pushes queue their expected {pc, instr, exc}; a monitor on the
// falling edge pops and compares whenever decode takes the head entry.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 32 + 32 + 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [4:0]       out_exc;
  logic [CNT_W-1:0] out_count;

  logic [ENT_W-1:0] exp_q[$];
  int total;
  int bad;

  fetch_queue #(
    .DEPTH(DEPTH),
    .ADDR_BASE(32'h0000_3000),
    .ADDR_LIMIT(32'h0000_6FFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_exc(out_exc),
    .out_count(out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected entry for a pushed pair: bad address -> exc 4 and zero instr.
  function automatic logic [ENT_W-1:0] expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    if (pc[1:0] != 2'b00 || pc < 32'h0000_3000 || pc > 32'h0000_6FFF)
      return {pc, 32'h0, 5'd4};
    return {pc, instr, 5'd0};
  endfunction

  // ---------------- driver ----------------
  // One clock cycle with the currently driven inputs; records an accepted push.
  task automatic step(output logic accepted);
    @(negedge clk);
    accepted = reset && in_valid && in_ready && !flush;
    if (accepted) exp_q.push_back(expect_entry(in_pc, in_instr));
    if (reset && flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    logic acc;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) step(acc);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout actual=%h required=accepted", pc);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      step(acc);
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    check("drain_scoreboard", exp_q.size(), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [ENT_W-1:0] e;
    if (reset && !flush && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected actual=%h required=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e[68:37] || out_instr !== e[36:5] || out_exc !== e[4:0]) begin
          bad++;
          $display("FAIL sb_entry actual=%h/%h/%0d required=%h/%h/%0d",
                   out_pc, out_instr, out_exc, e[68:37], e[36:5], e[4:0]);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic acc;
    logic [31:0] next_pc;
    logic [31:0] pcs_033 [4];
    total = 0;
    bad = 0;
    in_valid = 1'b0;
    in_pc = '0;
    in_instr = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {29'd0, out_count}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++) push_one(32'h3000 + 32'(i * 4), 32'hA + 32'(i));
    check("full_count", {29'd0, out_count}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_pc", out_pc, 32'h3000);
    check("full_out_instr", out_instr, 32'hA);
    check("full_out_exc", {27'd0, out_exc}, 32'd0);

    // Six cycles of push+pop from full; pointers wrap.
    out_ready = 1'b1;
    in_valid = 1'b1;
    next_pc = 32'h3010;
    for (int c = 0; c < 6; c++) begin
      in_pc = next_pc;
      in_instr = 32'h100 + next_pc;
      step(acc);
      if (acc) next_pc = next_pc + 32'd4;
      if (c == 0) check("ready_after_pop", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    check("wrap_count", {29'd0, out_count}, 32'd3);
    check("wrap_head", out_pc, 32'h3018);
    drain();

    // Address checks: misaligned, below base, above limit, last legal word.
    pcs_033[0] = 32'h3002;
    pcs_033[1] = 32'h2FFC;
    pcs_033[2] = 32'h7000;
    pcs_033[3] = 32'h6FFC;
    push_one(pcs_033[0], 32'hDEAD0001);
    check("misalign_exc", {27'd0, out_exc}, 32'd4);
    check("misalign_instr", out_instr, 32'd0);
    for (int i = 1; i < 4; i++) push_one(pcs_033[i], 32'hDEAD0001 + 32'(i));
    drain();
    push_one(32'h6FFC, 32'h1234_5678);
    check("limit_ok_exc", {27'd0, out_exc}, 32'd0);
    check("limit_ok_instr", out_instr, 32'h1234_5678);
    push_one(32'h7000, 32'h5555_5555);
    drain();

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) push_one(32'h3400 + 32'(i * 4), 32'h40 + 32'(i));
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h3500;
    in_instr = 32'h50;
    out_ready = 1'b1;
    step(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("flush_count", {29'd0, out_count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_pc", out_pc, 32'd0);
    push_one(32'h3600, 32'h60);
    check("post_flush_head", out_pc, 32'h3600);
    drain();

    // Steady state at count=2 with push and pop every cycle.
    push_one(32'h4000, 32'h70);
    push_one(32'h4004, 32'h71);
    out_ready = 1'b1;
    in_valid = 1'b1;
    next_pc = 32'h4008;
    for (int c = 0; c < 10; c++) begin
      in_pc = next_pc;
      in_instr = 32'h72 + 32'(c);
      step(acc);
      if (acc) next_pc = next_pc + 32'd4;
      check("steady_count", {29'd0, out_count}, 32'd2);
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset between edges drops queued entries.
    for (int i = 0; i < 3; i++) push_one(32'h5000 + 32'(i * 4), 32'h80 + 32'(i));
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_count", {29'd0, out_count}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    push_one(32'h3000, 32'h90);
    check("post_rst_head", out_pc, 32'h3000);
    check("post_rst_count", {29'd0, out_count}, 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
